// File: rtl/raster_pkg.sv
// Shared rasterizer types: vertex/area widths, triangle bundle, setup FSM
// states and the signed cross-product term used for the doubled area.
package raster_pkg;

  localparam int VX_W              = 9;
  localparam int VY_W              = 8;
  localparam int Z_W               = 16;
  localparam int COLOR_W           = 8;
  localparam int AREA_W            = 20;
  localparam int DEN_W             = 19;
  localparam int INV_AREA_W        = 32;
  localparam int DEFAULT_FRAC_BITS = 24;

  typedef struct packed {
    logic [VX_W-1:0]       v1x;
    logic [VY_W-1:0]       v1y;
    logic [VX_W-1:0]       v2x;
    logic [VY_W-1:0]       v2y;
    logic [VX_W-1:0]       v3x;
    logic [VY_W-1:0]       v3y;
    logic [COLOR_W-1:0]    color;
    logic [Z_W-1:0]        z1;
    logic [Z_W-1:0]        z2;
    logic [Z_W-1:0]        z3;
    logic [INV_AREA_W-1:0] inv_area;
  } triangle_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_AREA = 2'd1,
    S_DIV  = 2'd2,
    S_OUT  = 2'd3
  } setup_state_t;

  // x * (ya - yb) with the Y difference taken in VY_W+1 bits so it cannot
  // overflow, and everything sign-extended to the area width.
  function automatic logic signed [AREA_W-1:0] cross_term(
    input logic [VX_W-1:0] x,
    input logic [VY_W-1:0] ya,
    input logic [VY_W-1:0] yb
  );
    logic [VY_W:0]            dy;
    logic signed [AREA_W-1:0] xe;
    logic signed [AREA_W-1:0] dye;
    dy  = {ya[VY_W-1], ya} - {yb[VY_W-1], yb};
    xe  = {{(AREA_W-VX_W){x[VX_W-1]}}, x};
    dye = {{(AREA_W-VY_W-1){dy[VY_W]}}, dy};
    return xe * dye;
  endfunction

endpackage

// File: rtl/recip_div.sv
// Restoring divider computing 2^FRAC_BITS / den, one quotient bit per cycle,
// MSB first. done is high during the final step; quot is valid while done.
module recip_div
  import raster_pkg::*;
#(
  parameter int FRAC_BITS = DEFAULT_FRAC_BITS,
  parameter int Q_W       = INV_AREA_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [DEN_W-1:0] den,
  output logic             done,
  output logic [Q_W-1:0]   quot
);

  localparam int            CW        = $clog2(FRAC_BITS + 1);
  localparam logic [CW-1:0] LAST_STEP = CW'(FRAC_BITS);

  logic                 r_busy;
  logic [CW-1:0]        r_cnt;
  logic [DEN_W-1:0]     r_den;
  logic [DEN_W-1:0]     r_rem;
  logic [FRAC_BITS-1:0] r_q;

  logic                 w_num_bit;
  logic [DEN_W:0]       w_trial;
  logic [DEN_W-1:0]     w_diff;
  logic                 w_ge;
  logic [DEN_W-1:0]     w_rem_next;

  // The numerator is a single one at bit FRAC_BITS, i.e. the first bit fed in.
  assign w_num_bit  = (r_cnt == '0);
  assign w_trial    = {r_rem, w_num_bit};
  assign w_ge       = (w_trial >= {1'b0, r_den});
  assign w_diff     = w_trial[DEN_W-1:0] - r_den;
  assign w_rem_next = w_ge ? w_diff : w_trial[DEN_W-1:0];

  assign done = r_busy && (r_cnt == LAST_STEP);
  assign quot = Q_W'({r_q, w_ge});

  // Step counter and busy flag: start loads, the last step retires.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_busy <= 1'b0;
      r_cnt  <= '0;
    end else if (start) begin
      r_busy <= 1'b1;
      r_cnt  <= '0;
    end else if (r_busy) begin
      if (r_cnt == LAST_STEP) begin
        r_busy <= 1'b0;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  // Partial remainder and quotient shift register.
  always_ff @(posedge clk) begin
    if (start) begin
      r_den <= den;
      r_rem <= '0;
      r_q   <= '0;
    end else if (r_busy) begin
      r_rem <= w_rem_next;
      r_q   <= {r_q[FRAC_BITS-2:0], w_ge};
    end
  end

endmodule

// File: rtl/triangle_setup.sv
// Triangle setup: captures a triangle, computes the doubled signed area,
// culls degenerate triangles, computes inv_area = 2^FRAC_BITS / |area_x2|
// and offers the bundle to the rasterizer with a held valid/ready handshake.
// Optional: define TRIANGLE_BACKFACE_CULL_EN to also drop negative-area
// (clockwise) triangles.
module triangle_setup
  import raster_pkg::*;
#(
  parameter int FRAC_BITS = DEFAULT_FRAC_BITS,
  parameter int CNT_W     = 16
) (
  input  logic                  axi_aclk,
  input  logic                  axi_aresetn,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [VX_W-1:0]       in_v1x,
  input  logic [VY_W-1:0]       in_v1y,
  input  logic [VX_W-1:0]       in_v2x,
  input  logic [VY_W-1:0]       in_v2y,
  input  logic [VX_W-1:0]       in_v3x,
  input  logic [VY_W-1:0]       in_v3y,
  input  logic [COLOR_W-1:0]    in_color,
  input  logic [Z_W-1:0]        in_z1,
  input  logic [Z_W-1:0]        in_z2,
  input  logic [Z_W-1:0]        in_z3,
  output logic [VX_W-1:0]       v1x,
  output logic [VY_W-1:0]       v1y,
  output logic [VX_W-1:0]       v2x,
  output logic [VY_W-1:0]       v2y,
  output logic [VX_W-1:0]       v3x,
  output logic [VY_W-1:0]       v3y,
  output logic [COLOR_W-1:0]    color,
  output logic [Z_W-1:0]        z1,
  output logic [Z_W-1:0]        z2,
  output logic [Z_W-1:0]        z3,
  output logic [INV_AREA_W-1:0] inv_area,
  output logic                  triangle_valid,
  input  logic                  triangle_ready,
  output logic                  busy,
  output logic [CNT_W-1:0]      cull_count
);

  setup_state_t             r_state;
  setup_state_t             w_next_state;
  triangle_t                r_tri;
  logic [CNT_W-1:0]         r_cull_count;

  logic signed [AREA_W-1:0] w_area;
  logic [DEN_W-1:0]         w_den;
  logic                     w_drop;
  logic                     w_in_ready;
  logic                     w_div_start;
  logic                     w_div_done;
  logic [INV_AREA_W-1:0]    w_quot;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

  function automatic logic [DEN_W-1:0] abs_area(input logic signed [AREA_W-1:0] a);
    return a[AREA_W-1] ? DEN_W'(-a) : DEN_W'(a);
  endfunction

  assign w_area = cross_term(r_tri.v1x, r_tri.v2y, r_tri.v3y)
                + cross_term(r_tri.v2x, r_tri.v3y, r_tri.v1y)
                + cross_term(r_tri.v3x, r_tri.v1y, r_tri.v2y);
  assign w_den  = abs_area(w_area);

`ifdef TRIANGLE_BACKFACE_CULL_EN
  assign w_drop = (w_area == '0) || w_area[AREA_W-1];
`else
  assign w_drop = (w_area == '0);
`endif

  recip_div #(
    .FRAC_BITS (FRAC_BITS),
    .Q_W       (INV_AREA_W)
  ) u_recip_div (
    .clk   (axi_aclk),
    .rst_n (axi_aresetn),
    .start (w_div_start),
    .den   (w_den),
    .done  (w_div_done),
    .quot  (w_quot)
  );

  // State register.
  always_ff @(posedge axi_aclk) begin
    if (!axi_aresetn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state decode, upstream ready and divider kick.
  always_comb begin
    w_next_state = r_state;
    w_in_ready   = 1'b0;
    w_div_start  = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_in_ready = axi_aresetn;
        if (in_valid) begin
          w_next_state = S_AREA;
        end
      end
      S_AREA: begin
        if (w_drop) begin
          w_next_state = S_IDLE;
        end else begin
          w_next_state = S_DIV;
          w_div_start  = 1'b1;
        end
      end
      S_DIV: begin
        if (w_div_done) begin
          w_next_state = S_OUT;
        end
      end
      S_OUT: begin
        if (triangle_ready) begin
          w_next_state = S_IDLE;
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // Output bundle capture, inv_area update and cull counter.
  always_ff @(posedge axi_aclk) begin
    if (!axi_aresetn) begin
      r_tri        <= '0;
      r_cull_count <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_tri.v1x   <= in_v1x;
            r_tri.v1y   <= in_v1y;
            r_tri.v2x   <= in_v2x;
            r_tri.v2y   <= in_v2y;
            r_tri.v3x   <= in_v3x;
            r_tri.v3y   <= in_v3y;
            r_tri.color <= in_color;
            r_tri.z1    <= in_z1;
            r_tri.z2    <= in_z2;
            r_tri.z3    <= in_z3;
          end
        end
        S_AREA: begin
          if (w_drop) begin
            r_cull_count <= sat_inc(r_cull_count);
          end
        end
        S_DIV: begin
          if (w_div_done) begin
            r_tri.inv_area <= w_quot;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready       = w_in_ready;
  assign triangle_valid = (r_state == S_OUT);
  assign busy           = (r_state != S_IDLE);
  assign cull_count     = r_cull_count;
  assign v1x            = r_tri.v1x;
  assign v1y            = r_tri.v1y;
  assign v2x            = r_tri.v2x;
  assign v2y            = r_tri.v2y;
  assign v3x            = r_tri.v3x;
  assign v3y            = r_tri.v3y;
  assign color          = r_tri.color;
  assign z1             = r_tri.z1;
  assign z2             = r_tri.z2;
  assign z3             = r_tri.z3;
  assign inv_area       = r_tri.inv_area;

endmodule

// File: tb/tb_triangle_setup.sv
// Directed + randomized bench for triangle_setup with a scoreboard queue:
// expected bundles are pushed on accept and popped on each handshake.
// Test-plan Y coordinates are shifted by -100 so they fit the signed 8-bit
// Y inputs; the doubled areas are unchanged by the translation.
module tb_triangle_setup;

  typedef struct {
    logic [127:0] fields;
    logic [31:0]  inv;
  } exp_t;

  logic        clk = 1'b0;
  logic        rstn;
  logic        in_valid;
  logic        in_ready;
  logic [8:0]  in_v1x, in_v2x, in_v3x;
  logic [7:0]  in_v1y, in_v2y, in_v3y;
  logic [7:0]  in_color;
  logic [15:0] in_z1, in_z2, in_z3;
  logic [8:0]  ov1x, ov2x, ov3x;
  logic [7:0]  ov1y, ov2y, ov3y;
  logic [7:0]  ocolor;
  logic [15:0] oz1, oz2, oz3;
  logic [31:0] inv_area;
  logic        triangle_valid;
  logic        triangle_ready;
  logic        busy;
  logic [15:0] cull_count;

  logic [127:0] obs_f;
  exp_t         sb[$];
  int           n_vec = 0;
  int           n_err = 0;
  int           exp_cull = 0;
  int           n_push = 0;
  int           n_pop = 0;
  int           cyc = 0;
  bit           rand_mode = 1'b0;

  triangle_setup dut (
    .axi_aclk       (clk),
    .axi_aresetn    (rstn),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_v1x         (in_v1x),
    .in_v1y         (in_v1y),
    .in_v2x         (in_v2x),
    .in_v2y         (in_v2y),
    .in_v3x         (in_v3x),
    .in_v3y         (in_v3y),
    .in_color       (in_color),
    .in_z1          (in_z1),
    .in_z2          (in_z2),
    .in_z3          (in_z3),
    .v1x            (ov1x),
    .v1y            (ov1y),
    .v2x            (ov2x),
    .v2y            (ov2y),
    .v3x            (ov3x),
    .v3y            (ov3y),
    .color          (ocolor),
    .z1             (oz1),
    .z2             (oz2),
    .z3             (oz3),
    .inv_area       (inv_area),
    .triangle_valid (triangle_valid),
    .triangle_ready (triangle_ready),
    .busy           (busy),
    .cull_count     (cull_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign obs_f = {21'd0, ov1x, ov1y, ov2x, ov2y, ov3x, ov3y, ocolor, oz1, oz2, oz3};

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] pack_f(input int x1, y1, x2, y2, x3, y3, col, z1, z2, z3);
    logic [8:0]  a1, a2, a3;
    logic [7:0]  b1, b2, b3, c;
    logic [15:0] d1, d2, d3;
    a1 = 9'(x1);  a2 = 9'(x2);  a3 = 9'(x3);
    b1 = 8'(y1);  b2 = 8'(y2);  b3 = 8'(y3);
    c  = 8'(col);
    d1 = 16'(z1); d2 = 16'(z2); d3 = 16'(z3);
    return {21'd0, a1, b1, a2, b2, a3, b3, c, d1, d2, d3};
  endfunction

  function automatic int model_area(input int x1, y1, x2, y2, x3, y3);
    return x1 * (y2 - y3) + x2 * (y3 - y1) + x3 * (y1 - y2);
  endfunction

  function automatic logic [31:0] model_inv(input int area);
    int m;
    m = (area < 0) ? -area : area;
    return 32'((1 << 24) / m);
  endfunction

  // Drive one triangle when the DUT is ready; update the scoreboard/cull model.
  task automatic send_tri(input int x1, y1, x2, y2, x3, y3, col, z1, z2, z3, output int acc);
    int   guard;
    int   area;
    exp_t e;
    guard = 0;
    @(negedge clk);
    while (in_ready !== 1'b1 && guard < 400) begin
      @(negedge clk);
      guard++;
    end
    check("accept_wait", 128'(in_ready), 128'd1);
    in_v1x = 9'(x1); in_v1y = 8'(y1);
    in_v2x = 9'(x2); in_v2y = 8'(y2);
    in_v3x = 9'(x3); in_v3y = 8'(y3);
    in_color = 8'(col);
    in_z1 = 16'(z1); in_z2 = 16'(z2); in_z3 = 16'(z3);
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    acc = cyc;
    in_valid = 1'b0;
    area = model_area(x1, y1, x2, y2, x3, y3);
`ifdef TRIANGLE_BACKFACE_CULL_EN
    if (area <= 0) begin
`else
    if (area == 0) begin
`endif
      exp_cull++;
    end else begin
      e.fields = pack_f(x1, y1, x2, y2, x3, y3, col, z1, z2, z3);
      e.inv    = model_inv(area);
      sb.push_back(e);
      n_push++;
    end
  endtask

  task automatic wait_drain(input string tag, input int budget);
    int i;
    i = 0;
    @(negedge clk);
    while ((sb.size() != 0 || busy !== 1'b0) && i < budget) begin
      @(negedge clk);
      i++;
    end
    check(tag, 128'({sb.size() != 0, busy}), 128'd0);
  endtask

  // Handshake monitor: optional random ready, pop and compare on transfer.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rand_mode) triangle_ready = ($urandom_range(0, 3) != 0);
      if (triangle_valid === 1'b1 && triangle_ready === 1'b1 && rstn === 1'b1) begin
        if (sb.size() == 0) begin
          n_vec++;
          n_err++;
          $error("FAIL unexpected_output observed=0x%0h expected=none", inv_area);
        end else begin
          e = sb.pop_front();
          n_pop++;
          check("hs_fields", obs_f, e.fields);
          check("hs_inv", 128'(inv_area), 128'(e.inv));
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    int lat;
    int x[3];
    int y[3];
    rstn = 1'b0; in_valid = 1'b0; triangle_ready = 1'b0;
    in_v1x = '0; in_v1y = '0; in_v2x = '0; in_v2y = '0; in_v3x = '0; in_v3y = '0;
    in_color = '0; in_z1 = '0; in_z2 = '0; in_z3 = '0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ctl", 128'({in_ready, triangle_valid, busy}), 128'd0);
    check("rst_cull", 128'(cull_count), 128'd0);
    check("rst_inv", 128'(inv_area), 128'd0);
    check("rst_fields", obs_f, 128'd0);
    rstn = 1'b1;
    @(negedge clk);
    check("rel_in_ready", 128'(in_ready), 128'd1);

    // Test 1: area +10000, ready held high
    @(posedge clk); #1 triangle_ready = 1'b1;
    send_tri(100, -50, 200, 50, 100, 50, 'hE0, 50, 50, 50, acc);
    lat = -1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (triangle_valid === 1'b1) begin
        lat = cyc - acc + 1;
        break;
      end
    end
    check("t1_latency", 128'(lat), 128'd27);
    @(negedge clk);
    check("t1_idle_next", 128'({triangle_valid, in_ready, busy}), 128'b010);
    check("t1_inv", 128'(inv_area), 128'h0000068D);
    check("t1_fields_kept", obs_f, pack_f(100, -50, 200, 50, 100, 50, 'hE0, 50, 50, 50));
    check("t1_sb_empty", 128'(sb.size()), 128'd0);

    // Test 2: area -5000
    send_tri(200, -50, 150, 0, 250, 0, 'h1C, 7, 8, 9, acc);
`ifdef TRIANGLE_BACKFACE_CULL_EN
    @(negedge clk);
    @(negedge clk);
    check("t2_ready_back", 128'({in_ready, busy}), 128'b10);
    check("t2_cull", 128'(cull_count), 128'd1);
`else
    wait_drain("t2_drain", 100);
    check("t2_inv", 128'(inv_area), 128'h00000D1B);
`endif

    // Test 3: degenerate and unit-area triangles
    send_tri(10, 10, 20, 20, 30, 30, 'h03, 1, 2, 3, acc);
    wait_drain("t3_drain", 100);
    check("t3_cull", 128'(cull_count), 128'(exp_cull));
    send_tri(0, 0, 1, 0, 0, 1, 'hFF, 4, 5, 6, acc);
    wait_drain("t4_drain", 100);
    check("t4_inv", 128'(inv_area), 128'h01000000);

    // Test 5: 100-cycle stall in OUT with in_valid asserted
    @(posedge clk); #1 triangle_ready = 1'b0;
    send_tri(-50, -20, 30, -60, 100, 90, 'h5A, 1000, 2000, 3000, acc);
    for (int i = 0; i < 60 && triangle_valid !== 1'b1; i++) @(negedge clk);
    check("t5_valid_seen", 128'(triangle_valid), 128'd1);
    in_v1x = 9'd77; in_v2y = 8'd5; in_z3 = 16'hBEEF; in_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      check("t5_hold_ctl", 128'({triangle_valid, in_ready, busy}), 128'b101);
      check("t5_hold_data", {obs_f[95:0], inv_area},
            {pack_f(-50, -20, 30, -60, 100, 90, 'h5A, 1000, 2000, 3000), 32'h0} |
            128'(model_inv(14800)));
    end
    in_valid = 1'b0;
    @(posedge clk); #1 triangle_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("t5_release", 128'({triangle_valid, in_ready}), 128'b01);
    check("t5_single", 128'(sb.size()), 128'd0);

    // Test 6: reset during the divider
    send_tri(-100, -100, 100, -100, 0, 100, 'h11, 9, 9, 9, acc);
    repeat (10) @(posedge clk);
    #1 rstn = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("t6_rst_ctl", 128'({triangle_valid, busy, in_ready}), 128'd0);
    check("t6_rst_inv", 128'(inv_area), 128'd0);
    check("t6_rst_cull", 128'(cull_count), 128'd0);
    check("t6_rst_fields", obs_f, 128'd0);
    rstn = 1'b1;
    n_push = n_push - sb.size();
    sb.delete();
    exp_cull = 0;
    send_tri(0, 0, 64, 0, 0, 32, 'h22, 10, 20, 30, acc);
    wait_drain("t6_drain", 100);
    check("t6_inv", 128'(inv_area), 128'h00002000);

    // Test 7: 500 random triangles with random ready stalls
    rand_mode = 1'b1;
    for (int n = 0; n < 500; n++) begin
      for (int k = 0; k < 3; k++) begin
        x[k] = int'($urandom_range(0, 511)) - 256;
        y[k] = int'($urandom_range(0, 255)) - 128;
      end
      send_tri(x[0], y[0], x[1], y[1], x[2], y[2], int'($urandom_range(0, 255)),
               int'($urandom_range(0, 65535)), int'($urandom_range(0, 65535)),
               int'($urandom_range(0, 65535)), acc);
    end
    wait_drain("rand_drain", 2000);
    rand_mode = 1'b0;
    check("rand_count", 128'(n_pop), 128'(n_push));
    check("rand_cull", 128'(cull_count), 128'(exp_cull));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/triangle_setup.md
# triangle_setup

Producer-side triangle setup stage feeding the rasterizer's `triangle_valid`/`triangle_ready` port in `hdmi_text_controller_v1_0_AXI`. It accepts raw screen-space vertices, color and per-vertex Z, and computes the signed doubled area by cross product. It culls degenerate triangles and computes the 8.24 fixed-point `inv_area` with a sequential restoring divider. It then presents the complete triangle bundle with a held valid/ready handshake, replacing the testbench/CPU backdoor that writes these fields today.

## Interface
- `FRAC_BITS`, 24: fractional bits of `inv_area`; numerator is 2^FRAC_BITS.
- `CNT_W`, 16: width of `cull_count`.
- `axi_aclk`  in  1  single clock.
- `axi_aresetn`  in  1  reset, synchronous, active-low.
- `in_valid`  in  1  upstream triangle valid.
- `in_ready`  out  1  high only in IDLE.
- `in_v1x`, `in_v2x`, `in_v3x`  in  9 each, signed  vertex X.
- `in_v1y`, `in_v2y`, `in_v3y`  in  8 each, signed  vertex Y.
- `in_color`  in  8  RRRGGGBB color.
- `in_z1`, `in_z2`, `in_z3`  in  16 each  vertex depth.
- `v1x`..`v3y`, `color`, `z1`..`z3`  out  same widths as inputs  registered copies of the accepted fields.
- `inv_area`  out  32  floor(2^FRAC_BITS / |area_x2|).
- `triangle_valid`  out  1  output bundle valid.
- `triangle_ready`  in  1  rasterizer ready.
- `busy`  out  1  state != IDLE.
- `cull_count`  out  CNT_W  saturating count of dropped triangles.

## Operation
- FSM states: IDLE, AREA, DIV, OUT.
- IDLE:
  - `in_ready=1`.
  - When `in_valid`, capture all inputs into output registers and go to AREA.
- AREA (1 cycle):
  - area_x2 = x1*(y2-y3) + x2*(y3-y1) + x3*(y1-y2), computed in 20-bit signed.
  - Y differences are sign-extended to 9 bits before multiplying.
  - If area_x2 == 0: increment `cull_count` (saturating at all-ones) and return to IDLE.
  - Otherwise load the divider with |area_x2| (19 bits unsigned) and go to DIV.
- DIV (FRAC_BITS+1 = 25 cycles):
  - Restoring division of 2^FRAC_BITS by |area_x2|, one quotient bit per cycle, MSB first.
  - Quotient is zero-extended to 32 bits and registered into `inv_area`, then go to OUT.
- OUT:
  - `triangle_valid=1`; all output fields are held stable.
  - On a cycle with `triangle_valid && triangle_ready`: go to IDLE and drop `triangle_valid` on the next edge.
- Vertices are never reordered; winding sign is used only by the culling option.
- Output fields keep the last accepted values after the transfer.

## Timing
- Reset values:
  - `in_ready=0` during reset, 1 on the first cycle after release.
  - `triangle_valid=0`, `busy=0`, `cull_count=0`.
  - `inv_area=0`; all vertex, color and Z outputs are 0.
- Accept happens on edge E. AREA occupies E+1. DIV occupies E+2..E+26. `triangle_valid` is high from E+27.
- With `triangle_ready` held high: handshake at E+27, IDLE at E+28, next accept no earlier than E+28. Peak throughput is one triangle per 28 cycles.
- A culled triangle returns to IDLE at E+2 and can accept again on that edge.
- `triangle_ready` asserted before `triangle_valid` has no effect. `triangle_valid` never drops without a handshake.
- `in_valid` outside IDLE is ignored, because `in_ready=0`.
- A reset asserted in any state forces IDLE on the next edge, abandons the in-flight triangle, and clears all outputs and the counter.

## Configuration
- `TRIANGLE_BACKFACE_CULL_EN`:
  - Defined: in AREA, triangles with area_x2 < 0 (clockwise in screen space) are also dropped and counted in `cull_count`.
  - Undefined: negative-area triangles proceed, using |area_x2|.

## Structure
- Shared package `raster_pkg`:
  - Vertex width constants `VX_W=9`, `VY_W=8`, `Z_W=16`, `AREA_W=20`, `INV_AREA_W=32`.
  - `FRAC_BITS` default value.
  - `triangle_t` packed struct holding three vertices, color, Z and `inv_area`.
  - `setup_state_t` enum.
- One sub-module, `recip_div`: restoring divider with `start`/`done` ports, numerator fixed at 2^FRAC_BITS, 19-bit divisor, 32-bit quotient. The FSM holds DIV until `done`.

## Test plan
- (100,50),(200,150),(100,150), color E0, Z 50/50/50, ready high → area_x2=+10000, `inv_area`=0x0000068D, valid at accept+27, fields unchanged.
- (200,50),(150,100),(250,100), color 1C → area_x2=−5000:
  - Macro undefined: `inv_area`=0x00000D1B.
  - Macro defined: no `triangle_valid`, `cull_count`=1, `in_ready` back at accept+2.
- Degenerate (10,10),(20,20),(30,30) → no output, `cull_count` increments. Unit area (0,0),(1,0),(0,1) → area_x2=+1, `inv_area`=0x01000000.
- Hold `triangle_ready` low for 100 cycles in OUT → `triangle_valid` and all fields stable, `in_ready=0`. Raise ready → single transfer, IDLE next cycle.
- Reset during DIV cycle 10 → next cycle IDLE, `triangle_valid=0`, `inv_area=0`, `cull_count=0`. A new triangle after reset completes with correct `inv_area`.
- Randomized 500 triangles vs floor(2^24/|area|) reference model, with random ready stalls → every `inv_area` matches and no triangle is lost or duplicated.
